// File: rtl/divider_32bit.sv
// -----------------------------------------------------------------------------
// divider_32bit
//
// Iterative restoring divider for the RV32M DIV, DIVU, REM and REMU
// instructions. One quotient bit is produced per clock. Each step performs a
// 33-bit trial subtraction (a + ~b + 1) and keeps the result only when it is
// non-negative. Signed operations divide the operand magnitudes and then fix
// up the signs in a final cycle. Every operation, including divide by zero
// and signed overflow, takes the same number of cycles.
//
// Ports:
//   clk       in   1   clock, rising edge
//   rst       in   1   synchronous active-high reset
//   start     in   1   request, sampled only while idle
//   op        in   2   00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
//   dividend  in  32   rs1, captured on the accepting edge
//   divisor   in  32   rs2, captured on the accepting edge
//   result    out 32   quotient or remainder, registered, held after done
//   busy      out  1   high from the accepting edge to the completing edge
//   done      out  1   one-cycle pulse when result becomes valid
// -----------------------------------------------------------------------------
module divider_32bit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] result,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } state_t;

    state_t      state_r;
    logic [1:0]  op_r;
    logic [31:0] rem_r;       // partial remainder; always below the divisor
    logic [31:0] quo_r;       // dividend bits shift out the top, quotient bits in
    logic [31:0] divisor_r;   // divisor magnitude
    logic [5:0]  count_r;
    logic        sign_q_r;
    logic        sign_rem_r;

    logic [32:0] shift_s;
    logic [32:0] trial_s;
    logic [31:0] quo_fix_s;
    logic [31:0] rem_fix_s;

    // Two's-complement magnitude; 0x80000000 maps to itself and is then
    // treated as an unsigned value.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    // Trial subtraction and final sign correction.
    always_comb begin
        shift_s   = {rem_r, quo_r[31]};
        // Remainder stays below the divisor, so the 33-bit difference never
        // wraps and bit 32 is a reliable sign.
        trial_s   = shift_s + {1'b1, ~divisor_r} + 33'd1;
        quo_fix_s = quo_r;
        rem_fix_s = rem_r;
        if (!op_r[0]) begin
            // A zero divisor leaves the all-ones quotient untouched.
            if (sign_q_r && (divisor_r != 32'd0)) begin
                quo_fix_s = ~quo_r + 32'd1;
            end else begin
                quo_fix_s = quo_r;
            end
            if (sign_rem_r) begin
                rem_fix_s = ~rem_r + 32'd1;
            end else begin
                rem_fix_s = rem_r;
            end
        end else begin
            quo_fix_s = quo_r;
            rem_fix_s = rem_r;
        end
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            op_r       <= 2'd0;
            rem_r      <= 32'd0;
            quo_r      <= 32'd0;
            divisor_r  <= 32'd0;
            count_r    <= 6'd0;
            sign_q_r   <= 1'b0;
            sign_rem_r <= 1'b0;
            result     <= 32'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        op_r    <= op;
                        rem_r   <= 32'd0;
                        count_r <= 6'd32;
                        busy    <= 1'b1;
                        state_r <= CALC;
                        if (!op[0]) begin
                            quo_r      <= abs32(dividend);
                            divisor_r  <= abs32(divisor);
                            sign_q_r   <= dividend[31] ^ divisor[31];
                            sign_rem_r <= dividend[31];
                        end else begin
                            quo_r      <= dividend;
                            divisor_r  <= divisor;
                            sign_q_r   <= 1'b0;
                            sign_rem_r <= 1'b0;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    if (!trial_s[32]) begin
                        rem_r <= trial_s[31:0];
                        quo_r <= {quo_r[30:0], 1'b1};
                    end else begin
                        rem_r <= shift_s[31:0];
                        quo_r <= {quo_r[30:0], 1'b0};
                    end
                    count_r <= count_r - 6'd1;
                    if (count_r == 6'd1) begin
                        state_r <= FIXUP;
                    end else begin
                        state_r <= CALC;
                    end
                end
                FIXUP: begin
                    result  <= op_r[1] ? rem_fix_s : quo_fix_s;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
